// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multicycle MIPS main control.
//   - 4-bit state encodings for the control FSM
//   - opcode values recognised in DECODE
//   - aluop, alusrcb and pcsrc select codes driven to the datapath
//   - ctrl_t: the packed control word produced by the output decoder
package mc_pkg;

    // FSM state encodings
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_TRAP    = 4'd12;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation requests to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // Next-PC selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Complete control word for one cycle
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the main control FSM and the datapath/memory.
//   opcode, mem_ready         : datapath/memory -> control
//   mem_req .. illegal        : control -> datapath/memory
// Modports: master = control FSM side, slave = datapath side.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
               instr_done, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
               instr_done, illegal
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: pure state -> control-word decoder (Moore part only).
//   state : current FSM state (mc_pkg S_* encoding)
//   ctrl  : control word for that state; unlisted fields are 0.
// Handshake qualification with mem_ready is applied by the caller, so this
// decoder can be reused unchanged by a pipelined variant.
module mc_ctrl_outdec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    // Map each state to its control word
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH2;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.branch     = 1'b1;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main control FSM for the MIPS core.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; forces all outputs to 0 while high
//   bus  : mc_ctrl_if master (opcode/mem_ready in, datapath controls out)
// Outputs are decoded from the state register; FETCH irwrite/pcwrite and the
// MEMWR completion pulse are additionally qualified by mem_ready.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   bus
);

    logic [3:0] state_r;
    logic [3:0] state_nxt_s;
    logic [5:0] opcode_r;
    ctrl_t      raw_s;
    ctrl_t      ctrl_s;

    mc_ctrl_outdec u_outdec (
        .state (state_r),
        .ctrl  (raw_s)
    );

    // Next-state selection
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH:   state_nxt_s = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_RTYPE:     state_nxt_s = S_EXECUTE;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
                    OP_ADDI:      state_nxt_s = S_ADDIEX;
                    OP_J:         state_nxt_s = S_JUMP;
                    default:      state_nxt_s = S_TRAP;
                endcase
            end
            // The IR may have moved on; decide from the opcode seen in DECODE
            S_MEMADR:  state_nxt_s = (opcode_r == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_nxt_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_nxt_s = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_nxt_s = S_ALUWB;
            S_ADDIEX:  state_nxt_s = S_ADDIWB;
            default:   state_nxt_s = S_FETCH;
        endcase
    end

    // State register and DECODE-time opcode latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_FETCH;
            opcode_r <= 6'b000000;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_DECODE) begin
                opcode_r <= bus.opcode;
            end else begin
                opcode_r <= opcode_r;
            end
        end
    end

    // Qualify handshake-dependent strobes and blank everything during reset
    always_comb begin
        ctrl_s = raw_s;
        if (state_r == S_FETCH) begin
            ctrl_s.irwrite = raw_s.irwrite & bus.mem_ready;
            ctrl_s.pcwrite = raw_s.pcwrite & bus.mem_ready;
        end else begin
            ctrl_s.irwrite = raw_s.irwrite;
            ctrl_s.pcwrite = raw_s.pcwrite;
        end
        if (state_r == S_MEMWR) begin
            ctrl_s.instr_done = raw_s.instr_done & bus.mem_ready;
        end else begin
            ctrl_s.instr_done = raw_s.instr_done;
        end
        // Combinational so a pending store's memwrite drops in the reset cycle
        if (rst) begin
            ctrl_s = CTRL_IDLE;
        end else begin
            ctrl_s = ctrl_s;
        end
    end

    assign bus.mem_req    = ctrl_s.mem_req;
    assign bus.iord       = ctrl_s.iord;
    assign bus.memwrite   = ctrl_s.memwrite;
    assign bus.irwrite    = ctrl_s.irwrite;
    assign bus.pcwrite    = ctrl_s.pcwrite;
    assign bus.branch     = ctrl_s.branch;
    assign bus.pcsrc      = ctrl_s.pcsrc;
    assign bus.alusrca    = ctrl_s.alusrca;
    assign bus.alusrcb    = ctrl_s.alusrcb;
    assign bus.aluop      = ctrl_s.aluop;
    assign bus.regdst     = ctrl_s.regdst;
    assign bus.memtoreg   = ctrl_s.memtoreg;
    assign bus.regwrite   = ctrl_s.regwrite;
    assign bus.instr_done = ctrl_s.instr_done;
    assign bus.illegal    = ctrl_s.illegal;

endmodule
